// File: rtl/gpio_key_in.sv
// Memory-mapped push-button input port for the 6502 core: synchronises and debounces
// each key, latches press/release events and raises a maskable level interrupt.
module gpio_key_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] keys,
    input  logic             cs,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [1:0] ADDR_STATE   = 2'd0;
    localparam logic [1:0] ADDR_PRESS   = 2'd1;
    localparam logic [1:0] ADDR_RELEASE = 2'd2;
    localparam logic [1:0] ADDR_MASK    = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_nxt;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] release_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] clr_press;
    logic [WIDTH-1:0] clr_release;
    logic             wr_en;
    logic             unused_din;

    // Raw pins are synchronised first; the idle level resets to "not pressed".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= INACTIVE;
            sync2 <= INACTIVE;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    assign pressed = sync2 ^ INACTIVE;

    always_comb begin
        state_nxt = state;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (pressed[i] != state[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    state_nxt[i] = pressed[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign rise = state_nxt & ~state;
    assign fall = ~state_nxt & state;

    // Bus: single-cycle, no handshake. A write commits on the clk edge where cs=1 and
    // we=1; a read is a combinational view while cs=1 and we=0 and has no side effects.
    assign wr_en       = cs & we;
    assign wr_data     = din[WIDTH-1:0];
    assign clr_press   = (wr_en && addr == ADDR_PRESS)   ? wr_data : '0;
    assign clr_release = (wr_en && addr == ADDR_RELEASE) ? wr_data : '0;
    assign unused_din  = ^din;

    // Clearing is applied before setting so a same-cycle event survives its W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_q   <= '0;
            release_q <= '0;
            mask_q    <= '0;
            irq       <= 1'b0;
        end else begin
            press_q   <= (press_q & ~clr_press) | rise;
            release_q <= (release_q & ~clr_release) | fall;
            if (wr_en && addr == ADDR_MASK) begin
                mask_q <= wr_data;
            end
            irq <= |((press_q | release_q) & mask_q);
        end
    end

    always_comb begin
        dout = '0;
        if (cs && !we) begin
            case (addr)
                ADDR_STATE:   dout[WIDTH-1:0] = state;
                ADDR_PRESS:   dout[WIDTH-1:0] = press_q;
                ADDR_RELEASE: dout[WIDTH-1:0] = release_q;
                ADDR_MASK:    dout[WIDTH-1:0] = mask_q;
                default:      dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_key_in.sv
// Bench for gpio_key_in: directed steps then random key/bus traffic, all checked
// against a sliding-window debounce model and a register model of the bus window.
module tb_gpio_key_in;

    localparam int WIDTH = 4;
    localparam int DC    = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] keys    = 4'hF;
    logic       cs      = 1'b0;
    logic       we      = 1'b0;
    logic [1:0] addr    = 2'd0;
    logic [7:0] din     = 8'h00;
    logic [7:0] dout;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [3:0] m_hist[$];
    logic [3:0] m_state, m_press, m_release, m_mask;
    logic       m_irq;
    logic [7:0] exp_q[$];

    gpio_key_in #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset_n(reset_n), .keys(keys), .cs(cs), .we(we),
        .addr(addr), .din(din), .dout(dout), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        repeat (DC + 2) m_hist.push_back(4'h0);
        m_state   = '0;
        m_press   = '0;
        m_release = '0;
        m_mask    = '0;
        m_irq     = 1'b0;
    endtask

    // A key's level is accepted once the pin (seen two edges late) has sat at the
    // opposite level for the last DC consecutive edges.
    task automatic model_edge();
        logic [3:0] new_state, press_n, rel_n;
        logic       stable;
        if (!reset_n) return;
        m_hist.push_back(~keys);
        void'(m_hist.pop_front());
        new_state = m_state;
        for (int i = 0; i < WIDTH; i++) begin
            stable = 1'b1;
            for (int j = 0; j < DC; j++) begin
                if (m_hist[j][i] == m_state[i]) stable = 1'b0;
            end
            if (stable) new_state[i] = ~m_state[i];
        end
        press_n = m_press;
        rel_n   = m_release;
        m_irq   = |((m_press | m_release) & m_mask);
        if (cs && we) begin
            if (addr == 2'd1) press_n = press_n & ~din[3:0];
            if (addr == 2'd2) rel_n   = rel_n & ~din[3:0];
            if (addr == 2'd3) m_mask  = din[3:0];
        end
        m_press   = press_n | (new_state & ~m_state);
        m_release = rel_n | (~new_state & m_state);
        m_state   = new_state;
    endtask

    task automatic check_outputs();
        check("irq", {7'b0, irq}, {7'b0, m_irq});
        exp_q.push_back({4'h0, m_state});
        exp_q.push_back({4'h0, m_press});
        exp_q.push_back({4'h0, m_release});
        exp_q.push_back({4'h0, m_mask});
        for (int a = 0; a < 4; a++) begin
            cs = 1'b1; we = 1'b0; addr = 2'(a);
            #1;
            check($sformatf("dout_a%0d", a), dout, exp_q.pop_front());
        end
        cs = 1'b1; we = 1'b1;
        #1;
        check("dout_wr", dout, 8'h00);
        cs = 1'b0; we = 1'b0;
        #1;
        check("dout_idle", dout, 8'h00);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        cycle();
        din = 8'h00;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        cs = 1'b1; we = 1'b0; addr = a;
        #1;
        check(tag, dout, exp);
        cs = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();
        chk_reg("rst_state", 2'd0, 8'h00);
        chk_reg("rst_mask", 2'd3, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);

        // Step 1: single press, 2+DC edge latency
        keys = 4'hE;
        repeat (5) cycle();
        chk_reg("s1_state_early", 2'd0, 8'h00);
        cycle();
        chk_reg("s1_state", 2'd0, 8'h01);
        chk_reg("s1_press", 2'd1, 8'h01);
        chk_reg("s1_release", 2'd2, 8'h00);

        // Step 2: 3-cycle glitch is rejected, 4-cycle pulse is accepted
        keys = 4'hC;
        repeat (3) cycle();
        keys = 4'hE;
        repeat (8) cycle();
        chk_reg("s2_glitch_state", 2'd0, 8'h01);
        chk_reg("s2_glitch_press", 2'd1, 8'h01);
        chk_reg("s2_glitch_rel", 2'd2, 8'h00);
        keys = 4'hC;
        repeat (4) cycle();
        keys = 4'hE;
        repeat (2) cycle();
        chk_reg("s2_pulse_press", 2'd1, 8'h03);
        repeat (3) cycle();
        chk_reg("s2_rel_early", 2'd2, 8'h00);
        cycle();
        chk_reg("s2_rel", 2'd2, 8'h02);

        // Step 3: W1C and set-wins
        bus_write(2'd1, 8'h01);
        chk_reg("s3_w1c", 2'd1, 8'h02);
        keys = 4'hC;
        repeat (5) cycle();
        bus_write(2'd1, 8'h02);
        chk_reg("s3_set_wins", 2'd1, 8'h02);

        // Step 4: interrupt masking
        keys = 4'hF;
        repeat (8) cycle();
        bus_write(2'd1, 8'hFF);
        bus_write(2'd2, 8'hFF);
        bus_write(2'd3, 8'h04);
        chk_reg("s4_cleared", 2'd1, 8'h00);
        keys = 4'hE;
        repeat (8) cycle();
        check("s4_irq_masked", {7'b0, irq}, 8'h00);
        chk_reg("s4_press0", 2'd1, 8'h01);
        keys = 4'hA;
        repeat (6) cycle();
        chk_reg("s4_press2", 2'd1, 8'h05);
        check("s4_irq_pre", {7'b0, irq}, 8'h00);
        cycle();
        check("s4_irq_set", {7'b0, irq}, 8'h01);
        bus_write(2'd1, 8'h04);
        check("s4_irq_hold", {7'b0, irq}, 8'h01);
        cycle();
        check("s4_irq_clr", {7'b0, irq}, 8'h00);

        // Step 5: read-only STATE, cs gating, MASK width
        bus_write(2'd0, 8'hFF);
        chk_reg("s5_state_ro", 2'd0, 8'h05);
        cs = 1'b0; we = 1'b0; addr = 2'd0;
        #1;
        check("s5_cs0", dout, 8'h00);
        bus_write(2'd3, 8'hFF);
        chk_reg("s5_mask", 2'd3, 8'h0F);
        bus_write(2'd3, 8'h04);

        // Step 6: asynchronous reset mid-debounce with key0 held
        keys = 4'hF;
        repeat (8) cycle();
        keys = 4'hE;
        repeat (3) cycle();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("s6_irq_async", {7'b0, irq}, 8'h00);
        chk_reg("s6_rel_async", 2'd2, 8'h00);
        chk_reg("s6_mask_async", 2'd3, 8'h00);
        repeat (2) cycle();
        reset_n = 1'b1;
        repeat (5) cycle();
        chk_reg("s6_press_early", 2'd1, 8'h00);
        cycle();
        chk_reg("s6_press", 2'd1, 8'h01);

        // Random key activity and bus traffic
        repeat (400) begin
            if ($urandom_range(0, 5) == 0) keys = 4'($urandom());
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                model_reset();
                cycle();
                reset_n = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                bus_write(2'($urandom()), 8'($urandom()));
            end else begin
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
